// File: rtl/hero_attack_ctl.sv
// Attack hitbox generator for both heroes: a rising edge on attack_btn opens one
// live window of ATTACK_TIME ticks followed by a COOLDOWN_TIME lockout.
module hero_attack_ctl #(
    parameter int SQUARE_SIDE   = 60,
    parameter int ATTACK_WIDTH  = 40,
    parameter int ATTACK_HEIGHT = 20,
    parameter int ATTACK_TIME   = 15,
    parameter int COOLDOWN_TIME = 30,
    parameter int PARK_X        = 1025,
    parameter int PARK_Y        = 0
) (
    input  logic        clk_div,
    input  logic        rst,
    input  logic        level_rst,
    input  logic [23:0] hero_x_pos,
    input  logic [23:0] hero_y_pos,
    input  logic        attack_btn,
    input  logic [1:0]  facing,
    output logic [23:0] hero_attack_x_pos,
    output logic [23:0] hero_attack_y_pos,
    output logic        attack_direction,
    output logic        attack_active
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ACTIVE   = 2'd1;
    localparam logic [1:0] ST_COOLDOWN = 2'd2;

    localparam logic [1:0] FACE_UP    = 2'd0;
    localparam logic [1:0] FACE_LEFT  = 2'd1;
    localparam logic [1:0] FACE_RIGHT = 2'd2;
    localparam logic [1:0] FACE_DOWN  = 2'd3;

    localparam int CNT_MAX = (ATTACK_TIME > COOLDOWN_TIME) ? ATTACK_TIME : COOLDOWN_TIME;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] ACTIVE_LAST = CNT_W'(ATTACK_TIME - 1);
    localparam logic [CNT_W-1:0] COOL_LAST   = CNT_W'(COOLDOWN_TIME - 1);

    localparam logic [11:0] SIDE   = 12'(SQUARE_SIDE);
    localparam logic [11:0] WIDTH  = 12'(ATTACK_WIDTH);
    localparam logic [11:0] CENTRE = 12'((SQUARE_SIDE - ATTACK_HEIGHT) / 2);
    localparam logic [11:0] PARK_X12 = 12'(PARK_X);
    localparam logic [11:0] PARK_Y12 = 12'(PARK_Y);

    logic [1:0]       state;
    logic [CNT_W-1:0] counter;
    logic             btn_prev;
    logic [1:0]       dir_q;
    logic             btn_edge;
    logic [1:0]       dir_hero2;
    logic [23:0]      box_x_next;
    logic [23:0]      box_y_next;

    // Additions saturate at the 12-bit screen limit instead of wrapping.
    function automatic logic [11:0] sat_add(input logic [11:0] a, input logic [11:0] b);
        logic [12:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[12] ? 12'hFFF : sum[11:0];
    endfunction

    function automatic logic [11:0] clamp_sub(input logic [11:0] a, input logic [11:0] b);
        return (a < b) ? 12'd0 : (a - b);
    endfunction

    function automatic logic [11:0] box_x(input logic [1:0] face, input logic [11:0] hx);
        case (face)
            FACE_RIGHT: return sat_add(hx, SIDE);
            FACE_LEFT:  return clamp_sub(hx, WIDTH);
            default:    return sat_add(hx, CENTRE);
        endcase
    endfunction

    function automatic logic [11:0] box_y(input logic [1:0] face, input logic [11:0] hy);
        case (face)
            FACE_UP:   return clamp_sub(hy, WIDTH);
            FACE_DOWN: return sat_add(hy, SIDE);
            default:   return sat_add(hy, CENTRE);
        endcase
    endfunction

    assign btn_edge = attack_btn & ~btn_prev;
    // Swapping the two facing bits exchanges LEFT and RIGHT and leaves UP/DOWN alone.
    assign dir_hero2  = {dir_q[0], dir_q[1]};
    assign box_x_next = {box_x(dir_hero2, hero_x_pos[23:12]), box_x(dir_q, hero_x_pos[11:0])};
    assign box_y_next = {box_y(dir_hero2, hero_y_pos[23:12]), box_y(dir_q, hero_y_pos[11:0])};

    always_ff @(posedge clk_div) begin
        if (rst || level_rst) begin
            state             <= ST_IDLE;
            counter           <= '0;
            btn_prev          <= 1'b0;
            dir_q             <= FACE_UP;
            hero_attack_x_pos <= {PARK_X12, PARK_X12};
            hero_attack_y_pos <= {PARK_Y12, PARK_Y12};
            attack_direction  <= 1'b1;
            attack_active     <= 1'b0;
        end else begin
            btn_prev <= attack_btn;

            case (state)
                ST_IDLE: begin
                    if (btn_edge) begin
                        state   <= ST_ACTIVE;
                        counter <= '0;
                        dir_q   <= facing;
                    end
                end
                ST_ACTIVE: begin
                    if (counter == ACTIVE_LAST) begin
                        state   <= ST_COOLDOWN;
                        counter <= '0;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                ST_COOLDOWN: begin
                    if (counter == COOL_LAST) begin
                        state   <= ST_IDLE;
                        counter <= '0;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    counter <= '0;
                end
            endcase

            // Outputs follow the current state, giving one tick of latency after the edge.
            if (state == ST_ACTIVE) begin
                hero_attack_x_pos <= box_x_next;
                hero_attack_y_pos <= box_y_next;
                attack_direction  <= dir_q[0] ^ dir_q[1];
                attack_active     <= 1'b1;
            end else begin
                hero_attack_x_pos <= {PARK_X12, PARK_X12};
                hero_attack_y_pos <= {PARK_Y12, PARK_Y12};
                attack_active     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hero_attack_ctl.sv
// Bench for hero_attack_ctl: a timeline model of attack windows checked every tick,
// plus directed scenarios with hand-computed hitbox values.
module tb_hero_attack_ctl;

    localparam int ATT_TICKS  = 15;
    localparam int COOL_TICKS = 30;

    logic        clk_div = 1'b0;
    logic        rst;
    logic        level_rst;
    logic [23:0] hero_x_pos;
    logic [23:0] hero_y_pos;
    logic        attack_btn;
    logic [1:0]  facing;
    logic [23:0] hero_attack_x_pos;
    logic [23:0] hero_attack_y_pos;
    logic        attack_direction;
    logic        attack_active;

    int tests_run    = 0;
    int tests_failed = 0;

    hero_attack_ctl dut (
        .clk_div           (clk_div),
        .rst               (rst),
        .level_rst         (level_rst),
        .hero_x_pos        (hero_x_pos),
        .hero_y_pos        (hero_y_pos),
        .attack_btn        (attack_btn),
        .facing            (facing),
        .hero_attack_x_pos (hero_attack_x_pos),
        .hero_attack_y_pos (hero_attack_y_pos),
        .attack_direction  (attack_direction),
        .attack_active     (attack_active)
    );

    always #5 clk_div = ~clk_div;

    // Model state: tick index of the last accepted press, and what the outputs must be.
    int          t = 0;
    bit          started = 0;
    bit          have_win = 0;
    bit          prev_btn = 0;
    int          win_t = 0;
    int          face_l = 0;
    logic [23:0] m_x;
    logic [23:0] m_y;
    logic        m_dir;
    logic        m_act;

    function automatic int sat(input int v);
        return (v > 4095) ? 4095 : v;
    endfunction

    function automatic int floor0(input int v);
        return (v < 0) ? 0 : v;
    endfunction

    function automatic void place(input int face, input int hx, input int hy,
                                  output int bx, output int by);
        case (face)
            2:       begin bx = sat(hx + 60);    by = sat(hy + 20);    end
            1:       begin bx = floor0(hx - 40); by = sat(hy + 20);    end
            0:       begin bx = sat(hx + 20);    by = floor0(hy - 40); end
            default: begin bx = sat(hx + 20);    by = sat(hy + 60);    end
        endcase
    endfunction

    always @(posedge clk_div) begin
        int b1x, b1y, b2x, b2y, f2;
        t = t + 1;
        if (rst || level_rst) begin
            started  = 1;
            have_win = 0;
            prev_btn = 0;
            m_x   = {12'd1025, 12'd1025};
            m_y   = 24'd0;
            m_dir = 1'b1;
            m_act = 1'b0;
        end else begin
            // A press counts only once the previous window and its cooldown are fully over.
            if (attack_btn && !prev_btn && (!have_win || (t - win_t) > ATT_TICKS + COOL_TICKS)) begin
                have_win = 1;
                win_t    = t;
                face_l   = int'(facing);
            end
            prev_btn = attack_btn;
            if (have_win && (t - win_t) >= 1 && (t - win_t) <= ATT_TICKS) begin
                f2 = (face_l == 1) ? 2 : (face_l == 2) ? 1 : face_l;
                place(face_l, int'(hero_x_pos[11:0]), int'(hero_y_pos[11:0]), b1x, b1y);
                place(f2, int'(hero_x_pos[23:12]), int'(hero_y_pos[23:12]), b2x, b2y);
                m_x   = {12'(b2x), 12'(b1x)};
                m_y   = {12'(b2y), 12'(b1y)};
                m_dir = (face_l == 1 || face_l == 2);
                m_act = 1'b1;
            end else begin
                m_x   = {12'd1025, 12'd1025};
                m_y   = 24'd0;
                m_act = 1'b0;
            end
        end
    end

    task automatic check_output(input string name, input logic [23:0] act, input logic [23:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h at t=%0d", name, act, exp, t);
        end
    endtask

    always @(negedge clk_div) begin
        if (started) begin
            check_output("model_x", hero_attack_x_pos, m_x);
            check_output("model_y", hero_attack_y_pos, m_y);
            check_output("model_dir", {23'd0, attack_direction}, {23'd0, m_dir});
            check_output("model_active", {23'd0, attack_active}, {23'd0, m_act});
        end
    end

    task automatic apply_stimulus(input int n);
        repeat (n) @(posedge clk_div);
        #1;
    endtask

    task automatic check_all(input string name, input logic [23:0] ex, input logic [23:0] ey,
                             input logic edir, input logic eact);
        check_output({name, "_x"}, hero_attack_x_pos, ex);
        check_output({name, "_y"}, hero_attack_y_pos, ey);
        check_output({name, "_dir"}, {23'd0, attack_direction}, {23'd0, edir});
        check_output({name, "_active"}, {23'd0, attack_active}, {23'd0, eact});
    endtask

    initial begin
        rst        = 1'b1;
        level_rst  = 1'b0;
        attack_btn = 1'b0;
        facing     = 2'd2;
        hero_x_pos = {12'd600, 12'd300};
        hero_y_pos = {12'd200, 12'd200};

        apply_stimulus(2);
        check_all("reset", 24'h401401, 24'h000000, 1'b1, 1'b0);
        rst = 1'b0;
        apply_stimulus(1);

        // Facing RIGHT: hero1 box to the right, hero2 mirrored to the left.
        attack_btn = 1'b1;
        apply_stimulus(1);
        check_output("latency_active", {23'd0, attack_active}, 24'd0);
        apply_stimulus(1);
        check_all("right", {12'd560, 12'd360}, {12'd220, 12'd220}, 1'b1, 1'b1);
        apply_stimulus(14);
        check_output("last_live_tick", {23'd0, attack_active}, 24'd1);
        apply_stimulus(1);
        check_all("after_window", 24'h401401, 24'h000000, 1'b1, 1'b0);

        // Re-presses during cooldown are dropped, including one on the final cooldown tick.
        apply_stimulus(4);
        attack_btn = 1'b0;
        apply_stimulus(5);
        attack_btn = 1'b1;
        apply_stimulus(2);
        check_output("cooldown_press", {23'd0, attack_active}, 24'd0);
        apply_stimulus(16);
        attack_btn = 1'b0;
        apply_stimulus(1);
        attack_btn = 1'b1;
        apply_stimulus(1);
        check_output("last_cooldown_press", {23'd0, attack_active}, 24'd0);
        attack_btn = 1'b0;
        apply_stimulus(1);
        attack_btn = 1'b1;
        apply_stimulus(1);
        check_output("idle_press_latency", {23'd0, attack_active}, 24'd0);
        apply_stimulus(1);
        check_output("idle_press_live", {23'd0, attack_active}, 24'd1);

        // Mid-window facing change must not move the side; hero motion is tracked.
        facing     = 2'd1;
        hero_x_pos = {12'd600, 12'd301};
        apply_stimulus(1);
        check_all("track", {12'd560, 12'd361}, {12'd220, 12'd220}, 1'b1, 1'b1);

        apply_stimulus(100);
        check_output("held_no_refire", {23'd0, attack_active}, 24'd0);

        // UP with clamp at the top edge, then abort via level restart.
        facing     = 2'd0;
        hero_x_pos = {12'd600, 12'd100};
        hero_y_pos = {12'd200, 12'd30};
        attack_btn = 1'b0;
        apply_stimulus(1);
        attack_btn = 1'b1;
        apply_stimulus(2);
        check_all("up_clamp", {12'd620, 12'd120}, {12'd160, 12'd0}, 1'b0, 1'b1);
        apply_stimulus(4);
        level_rst = 1'b1;
        apply_stimulus(1);
        check_all("level_rst", 24'h401401, 24'h000000, 1'b1, 1'b0);
        level_rst  = 1'b0;
        facing     = 2'd3;
        hero_y_pos = {12'd200, 12'd600};
        apply_stimulus(1);
        check_output("post_rst_latency", {23'd0, attack_active}, 24'd0);
        apply_stimulus(1);
        check_all("down", {12'd620, 12'd120}, {12'd260, 12'd660}, 1'b0, 1'b1);
        hero_x_pos = {12'd600, 12'd4090};
        hero_y_pos = {12'd200, 12'd4050};
        apply_stimulus(1);
        check_all("down_sat", {12'd620, 12'd4095}, {12'd260, 12'd4095}, 1'b0, 1'b1);

        // LEFT with clamp at x=0; hero2 goes RIGHT and saturates.
        apply_stimulus(50);
        attack_btn = 1'b0;
        facing     = 2'd1;
        hero_x_pos = {12'd4050, 12'd30};
        hero_y_pos = {12'd100, 12'd100};
        apply_stimulus(1);
        attack_btn = 1'b1;
        apply_stimulus(2);
        check_all("left_clamp", {12'd4095, 12'd0}, {12'd120, 12'd120}, 1'b1, 1'b1);
        apply_stimulus(20);
        attack_btn = 1'b0;
        apply_stimulus(2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
